// File: rtl/rx_fifo.sv
// rx_fifo: receive buffer between rx_core and the register/Avalon side.
//
// Each rising edge of rx_done captures rx_data into a DEPTH-entry synchronous
// FIFO, where DEPTH = 2**ADDR_W. The reader pops bytes with rd_req. Each pop
// returns a registered rd_data together with a one-cycle rd_valid pulse in the
// following cycle.
//
// Ports:
//   rx_clk      in   clock shared with rx_core
//   reset_n     in   asynchronous active-low reset
//   rx_data     in   received byte, sampled only on a push cycle
//   rx_done     in   byte-complete level; one push per rising edge
//   rd_req      in   pop request; ignored while empty
//   clr_overrun in   clears the sticky overrun flag
//   rd_data     out  last popped byte (holds between pops)
//   rd_valid    out  one-cycle pulse: rd_data was just updated by a pop
//   empty       out  count == 0
//   full        out  count == DEPTH
//   count       out  stored entries, 0..DEPTH
//   overrun     out  sticky: a byte was dropped because the FIFO was full
module rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              rx_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rd_req,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int unsigned          DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]      CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]      CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overrun;
  logic              r_rx_done_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_push_acc;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // rx_done_d resets high so that an rx_done already asserted at reset
  // release does not count as a rising edge.
  assign w_push     = rx_done & ~r_rx_done_d;
  // empty comes from the registered count, so a push in the same cycle
  // cannot be read back through a bypass.
  assign w_pop      = rd_req & ~w_empty;
  // When full, a simultaneous pop frees the slot that the push then uses.
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  // Storage is intentionally left without a reset.
  always_ff @(posedge rx_clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_done_d <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_done_d <= rx_done;
      r_rd_valid  <= w_pop;

      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end

      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
      end

      if (w_push_acc && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push_acc) begin
        r_count <= r_count - CNT_ONE;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overrun  = r_overrun;

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
Receive buffer directly downstream of rx_core in the UART slave.
- Captures each byte rx_core completes (rx_data qualified by rx_done) into a synchronous FIFO.
- Presents the bytes to the Avalon-facing register logic through a pop/valid read interface.
- Reports occupancy, full/empty, and a sticky overrun flag.

Parameters:
DATA_W, 8, width of rx_data and stored words
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (16 by default)

Ports:
rx_clk  input  1  single clock for the whole block (same clock as rx_core)
reset_n  input  1  asynchronous active-low reset
rx_data  input  DATA_W  received byte from rx_core; valid while rx_done is high
rx_done  input  1  byte-complete indication from rx_core; may stay high for more than one cycle
rd_req  input  1  pop request from the register/Avalon side
clr_overrun  input  1  clears the sticky overrun flag
rd_data  output  DATA_W  popped byte, registered
rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped byte
empty  output  1  no entries stored
full  output  1  DEPTH entries stored
count  output  ADDR_W+1  number of stored entries, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, reset_n low): all outputs and state are forced immediately.
  - wr_ptr = 0, rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0, overrun = 0.
  - empty = 1, full = 0.
  - Internal rx_done_d = 1.
  - Storage contents are not reset.
  - Reset mid-operation discards all stored bytes.
- Push detection:
  - push = rx_done & ~rx_done_d, where rx_done_d is rx_done registered every rx_clk edge.
  - Exactly one push per rx_done rising edge, regardless of pulse length.
  - Because rx_done_d resets to 1, an rx_done already high at reset release is not captured.
- Push accepted when push & (~full | pop):
  - mem[wr_ptr] <= rx_data.
  - wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Pop:
  - pop = rd_req & ~empty.
  - On pop: rd_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH, rd_valid = 1 in the next cycle.
  - Latency: the rd_req cycle is N; data and pulse appear at N+1.
  - rd_req while empty is ignored: rd_valid stays 0, rd_data holds, no state change.
  - rd_data holds its last popped value when rd_valid = 0.
- count update:
  - +1 on accepted push only.
  - −1 on pop only.
  - Unchanged on both or neither.
  - empty = (count == 0); full = (count == DEPTH). Both are derived combinationally from registered count.
- Simultaneous push and pop:
  - When full: both proceed (the pop frees the slot the push uses), count stays DEPTH, nothing dropped.
  - When empty: pop is ignored (empty is evaluated before the push), push is stored, count becomes 1.
  - No write-to-read bypass: a byte is readable at the earliest one cycle after its push.
- Overrun:
  - push & full & ~pop drops the byte; pointers and count are unchanged and overrun <= 1.
  - overrun stays set until clr_overrun.
  - If clr_overrun and a new drop occur in the same cycle, set wins (overrun = 1).
- Ordering: strict FIFO order. Pointers wrap after DEPTH operations with no data corruption.
- rx_data is sampled only on the push cycle. Other values are don't-care.

Test Plan:
1. Reset with rx_done held high, release, hold rx_done high 5 more cycles → count = 0, empty = 1; then drop rx_done and pulse once with 0x5A → count = 1; rd_req one cycle → next cycle rd_valid = 1, rd_data = 0x5A, empty = 1.
2. Push 16 bytes 0x00..0x0F (rx_done high 3 cycles each) → full = 1, count = 16; push 0xAA → overrun = 1, count = 16; pop 16 → data 0x00..0x0F in order, 0xAA never appears, empty = 1.
3. With FIFO full, assert push (0x77) and rd_req in the same cycle → count stays 16, overrun = 0, the 16th subsequent pop returns 0x77.
4. rd_req while empty → rd_valid stays 0, rd_data unchanged; with empty, same-cycle push 0x33 and rd_req → rd_valid = 0, count = 1; next rd_req returns 0x33.
5. Interleave 40 push/pop pairs with random data (pointer wrap twice) → every popped byte equals the pushed sequence; count never exceeds 1; then clr_overrun coinciding with an overflow push → overrun remains 1; clr_overrun alone next cycle → 0.
6. Assert reset_n low with 7 entries stored and rd_req high → all outputs at reset values immediately; after release, empty = 1 and rd_req yields no rd_valid.
